// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader that streams a length-prefixed image into the imem write port
module imem_loader #(
  parameter logic [31:0] START_ADDR = 32'h01000000,
  parameter int unsigned MEM_DEPTH  = 1048576
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  localparam logic [31:0] MAX_WORDS = 32'(MEM_DEPTH / 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_FLUSH,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state, state_next;
  logic [1:0]  byte_idx;
  logic [31:0] word_cnt;
  logic [31:0] count;
  logic [23:0] asm_word;

  logic        xfer;
  logic        start_ok;
  logic        last_byte;
  logic [31:0] len_value;

  assign xfer      = in_valid && in_ready;
  assign last_byte = xfer && (byte_idx == 2'd3);
  assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  // Little-endian: each new byte enters at the top and older bytes shift down.
  assign len_value = {in_data, count[31:8]};

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LEN;
      end
      S_LEN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_byte) begin
          if (len_value == 32'd0)          state_next = S_DONE;
          else if (len_value > MAX_WORDS)  state_next = S_ERROR;
          else                             state_next = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_byte && (word_cnt == count - 32'd1)) state_next = S_FLUSH;
      end
      S_FLUSH: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_next = S_LEN;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) state_next = S_LEN;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      byte_idx <= 2'd0;
      word_cnt <= 32'd0;
      count    <= 32'd0;
      asm_word <= 24'd0;
      wr_en    <= 1'b0;
      wr_addr  <= START_ADDR;
      wr_data  <= 32'd0;
    end else begin
      state <= state_next;
      wr_en <= 1'b0;
      if (start_ok) begin
        byte_idx <= 2'd0;
        word_cnt <= 32'd0;
        count    <= 32'd0;
        wr_addr  <= START_ADDR;
      end
      if (xfer) begin
        byte_idx <= byte_idx + 2'd1;
        if (state == S_LEN) begin
          count <= len_value;
        end else if (byte_idx == 2'd3) begin
          wr_en    <= 1'b1;
          wr_data  <= {in_data, asm_word};
          wr_addr  <= START_ADDR + (word_cnt << 2);
          word_cnt <= word_cnt + 32'd1;
        end else begin
          asm_word <= {in_data, asm_word[23:8]};
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

  localparam logic [31:0] S = 32'h01000000;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  int checks = 0;
  int errors = 0;

  logic [63:0] wq[$];
  int          run_len = 0;
  int          max_run = 0;

  imem_loader dut (
    .clock(clock), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wr_en) begin
      wq.push_back({wr_addr, wr_data});
      run_len = run_len + 1;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic [69:0] exp;
  } vec_t;

  function automatic logic [69:0] mk(logic ir, logic we, logic b, logic d, logic e, logic h,
                                     logic [31:0] a, logic [31:0] w);
    return {ir, we, b, d, e, h, a, w};
  endfunction

  function automatic logic [69:0] outs();
    return {in_ready, wr_en, busy, done, error, cpu_hold, wr_addr, wr_data};
  endfunction

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 70'd0, 70'd1);
    end else begin
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!done && !error && n < 200) begin
      tick();
      n++;
    end
    if (!done && !error) chk("end_timeout", 70'd0, 70'd1);
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, outs(), mk(0, 0, 0, 0, 0, 1, S, 32'd0));
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1, 0, 8'h00, mk(1, 0, 1, 0, 0, 1, S, 32'd0)};
    vecs[1]  = '{0, 1, 8'h02, mk(1, 0, 1, 0, 0, 1, S, 32'd0)};
    vecs[2]  = '{0, 1, 8'h00, mk(1, 0, 1, 0, 0, 1, S, 32'd0)};
    vecs[3]  = '{0, 1, 8'h00, mk(1, 0, 1, 0, 0, 1, S, 32'd0)};
    vecs[4]  = '{0, 1, 8'h00, mk(1, 0, 1, 0, 0, 1, S, 32'd0)};
    vecs[5]  = '{0, 1, 8'h13, mk(1, 0, 1, 0, 0, 1, S, 32'd0)};
    vecs[6]  = '{0, 1, 8'h05, mk(1, 0, 1, 0, 0, 1, S, 32'd0)};
    vecs[7]  = '{0, 1, 8'h00, mk(1, 0, 1, 0, 0, 1, S, 32'd0)};
    vecs[8]  = '{0, 1, 8'h00, mk(1, 1, 1, 0, 0, 1, S, 32'h00000513)};
    vecs[9]  = '{0, 1, 8'h93, mk(1, 0, 1, 0, 0, 1, S, 32'h00000513)};
    vecs[10] = '{0, 1, 8'h05, mk(1, 0, 1, 0, 0, 1, S, 32'h00000513)};
    vecs[11] = '{0, 1, 8'h10, mk(1, 0, 1, 0, 0, 1, S, 32'h00000513)};
    vecs[12] = '{0, 1, 8'h00, mk(0, 1, 1, 0, 0, 1, S + 4, 32'h00100593)};
    vecs[13] = '{0, 0, 8'h00, mk(0, 0, 0, 1, 0, 0, S + 4, 32'h00100593)};
    vecs[14] = '{0, 1, 8'hAA, mk(0, 0, 0, 1, 0, 0, S + 4, 32'h00100593)};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick(); tick();
    chk_reset_vals("reset_values");
    reset = 1'b0;
    tick();
    chk_reset_vals("idle_after_reset");

    // 1: cycle-accurate table for the two-word image
    for (int i = 0; i < 15; i++) begin
      start = vecs[i].start; in_valid = vecs[i].valid; in_data = vecs[i].data;
      tick();
      chk($sformatf("t1_row%0d", i), outs(), vecs[i].exp);
    end
    start = 1'b0; in_valid = 1'b0;

    // 2: same image with in_valid toggling
    wq.delete(); max_run = 0;
    pulse_start();
    chk("t2_cpu_hold_back", {69'd0, cpu_hold}, 70'd1);
    send_word(32'd2, 1);
    send_word(32'h00000513, 1);
    send_word(32'h00100593, 1);
    wait_end();
    chk("t2_nwrites", 70'(wq.size()), 70'd2);
    if (wq.size() == 2) begin
      chk("t2_w0", 70'(wq[0]), 70'({S, 32'h00000513}));
      chk("t2_w1", 70'(wq[1]), 70'({S + 4, 32'h00100593}));
    end
    chk("t2_max_run", 70'(max_run), 70'd1);
    chk("t2_done", {68'd0, done, cpu_hold}, 70'b10);

    // 3: over-capacity header, then recovery
    wq.delete();
    pulse_start();
    send_word(32'h00040001, 0);
    chk("t3_error", {66'd0, error, in_ready, busy, cpu_hold}, 70'b1001);
    in_valid = 1'b1; in_data = 8'h55;
    tick(); tick();
    chk("t3_error_held", {67'd0, error, in_ready, wr_en}, 70'b100);
    in_valid = 1'b0;
    chk("t3_no_writes", 70'(wq.size()), 70'd0);
    pulse_start();
    chk("t3_error_clear", {68'd0, error, busy}, 70'b01);
    send_word(32'd1, 0);
    send_word(32'hDEADBEEF, 0);
    wait_end();
    chk("t3_recover_done", {68'd0, done, error}, 70'b10);
    chk("t3_recover_nw", 70'(wq.size()), 70'd1);
    if (wq.size() == 1) chk("t3_recover_w0", 70'(wq[0]), 70'({S, 32'hDEADBEEF}));

    // 3b: exactly MEM_DEPTH/4 words is accepted
    pulse_start();
    send_word(32'h00040000, 0);
    chk("t3b_max_ok", {67'd0, busy, error, in_ready}, 70'b101);
    reset = 1'b1; #1;
    chk_reset_vals("t3b_reset");
    reset = 1'b0;
    tick();

    // 4: zero-length image
    wq.delete();
    pulse_start();
    send_word(32'd0, 0);
    chk("t4_done", {67'd0, done, cpu_hold, busy}, 70'b100);
    tick();
    chk("t4_no_writes", 70'(wq.size()), 70'd0);

    // 5: reset mid-load discards the partial word
    wq.delete();
    pulse_start();
    send_word(32'd3, 0);
    send_word(32'hAAAA0001, 0);
    send_word(32'hBBBB0002, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    tick();
    chk("t5_two_writes", 70'(wq.size()), 70'd2);
    #2 reset = 1'b1; #1;
    chk_reset_vals("t5_reset_async");
    tick();
    reset = 1'b0;
    wq.delete();
    pulse_start();
    send_word(32'd1, 0);
    send_word(32'h44332211, 0);
    wait_end();
    chk("t5_nw", 70'(wq.size()), 70'd1);
    if (wq.size() == 1) chk("t5_w0", 70'(wq[0]), 70'({S, 32'h44332211}));

    // 6: start during DATA and bytes in DONE are ignored
    wq.delete();
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'h0A0B0C0D, 0);
    pulse_start();
    chk("t6_start_ignored", {68'd0, busy, in_ready}, 70'b11);
    send_word(32'h01020304, 0);
    wait_end();
    in_valid = 1'b1; in_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t6_done_hold%0d", i), {67'd0, in_ready, done, wr_en}, 70'b010);
    end
    in_valid = 1'b0;
    chk("t6_nw", 70'(wq.size()), 70'd2);
    if (wq.size() == 2) begin
      chk("t6_w0", 70'(wq[0]), 70'({S, 32'h0A0B0C0D}));
      chk("t6_w1", 70'(wq[1]), 70'({S + 4, 32'h01020304}));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
